// File: rtl/pipe_core_pkg.sv
// Shared decode constants, ALU/forward selectors and stage-register control structs for pipe_core_fwd.
// Build option: FWD_EN (see pipe_core_fwd.sv).
package pipe_core_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT} alu_op_e;
  typedef enum logic [1:0] {FWD_RF, FWD_EXMEM, FWD_MEMWB} fwd_sel_e;

  // Control-only structs; XLEN-wide data travels in parallel registers since width is a module parameter.
  typedef struct packed {
    logic       valid;
    alu_op_e    alu_op;
    logic       use_imm;
    logic       is_load;
    logic       is_store;
    logic       we;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } id_ex_t;

  typedef struct packed {
    logic       valid;
    logic       is_load;
    logic       is_store;
    logic       we;
    logic [4:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [4:0] rd;
  } mem_wb_t;

  // A valid older writer of a non-zero rd that matches a source actually read.
  function automatic logic raw_hit(input logic valid, input logic we, input logic [4:0] rd,
                                   input logic [4:0] rs, input logic used);
    return valid && we && (rd != 5'd0) && (rd == rs) && used;
  endfunction

endpackage

// File: rtl/pipe_core_regfile.sv
// NREG x XLEN register file: two combinational reads, one write, write-through, x0 hardwired to 0.
module pipe_core_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Same-cycle WB write is visible to the ID read.
  assign rdata1 = (raddr1 == '0) ? '0 : ((we && (waddr == raddr1)) ? wdata : regs[raddr1]);
  assign rdata2 = (raddr2 == '0) ? '0 : ((we && (waddr == raddr2)) ? wdata : regs[raddr2]);

endmodule

// File: rtl/pipe_core_fwd.sv
// 5-stage in-order RV32I-subset pipeline (IF/ID/EX/MEM/WB) with retire port and perf counters.
// Define FWD_EN to enable the EX bypass network (load-use stalls only); otherwise RAW hazards interlock.
module pipe_core_fwd
  import pipe_core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter int              CNT_W    = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_insn,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  output logic             dmem_wen,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             retire_valid,
  output logic [XLEN-1:0]  retire_pc,
  output logic [4:0]       retire_rd,
  output logic [XLEN-1:0]  retire_data,
  output logic             illegal_seen,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

`ifdef FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  localparam int         RW       = $clog2(NREG);
  localparam logic [4:0] REG_MASK = 5'(NREG - 1);

  logic [XLEN-1:0]  pc;
  logic             if_valid;
  logic [31:0]      if_insn;
  logic [XLEN-1:0]  if_pc;
  id_ex_t           id_ex;
  logic [XLEN-1:0]  id_ex_pc, id_ex_a, id_ex_b, id_ex_imm;
  ex_mem_t          ex_mem;
  logic [XLEN-1:0]  ex_mem_pc, ex_mem_res, ex_mem_wdata;
  mem_wb_t          mem_wb;
  logic [XLEN-1:0]  mem_wb_pc, mem_wb_data;
  logic             illegal_q;
  logic [CNT_W-1:0] cyc_q, stall_q;

  id_ex_t           dec;
  logic [XLEN-1:0]  dec_imm, imm_i, imm_s, rf_rd1, rf_rd2;
  logic             dec_legal, dec_use_rs2, use_rs1, use_rs2;
  logic             hit_ex, hit_mem, stall;
  fwd_sel_e         sel_a, sel_b;
  logic [XLEN-1:0]  op_a, op_b, alu_b, alu_res;
  logic [2:0]       f3;
  logic [6:0]       f7;

  assign f3    = if_insn[14:12];
  assign f7    = if_insn[31:25];
  assign imm_i = {{(XLEN-12){if_insn[31]}}, if_insn[31:20]};
  assign imm_s = {{(XLEN-12){if_insn[31]}}, if_insn[31:25], if_insn[11:7]};

  always_comb begin
    dec         = '0;
    dec.rd      = if_insn[11:7] & REG_MASK;
    dec.rs1     = if_insn[19:15] & REG_MASK;
    dec.rs2     = if_insn[24:20] & REG_MASK;
    dec_imm     = imm_i;
    dec_legal   = 1'b0;
    dec_use_rs2 = 1'b0;
    case (if_insn[6:0])
      OPC_OP_IMM: begin
        dec_legal   = 1'b1;
        dec.we      = 1'b1;
        dec.use_imm = 1'b1;
        case (f3)
          F3_ADD:  dec.alu_op = ALU_ADD;
          F3_SLT:  dec.alu_op = ALU_SLT;
          F3_XOR:  dec.alu_op = ALU_XOR;
          F3_OR:   dec.alu_op = ALU_OR;
          F3_AND:  dec.alu_op = ALU_AND;
          default: dec_legal  = 1'b0;
        endcase
      end
      OPC_OP: begin
        dec.we      = 1'b1;
        dec_use_rs2 = 1'b1;
        dec_legal   = (f7 == F7_BASE) || ((f7 == F7_SUB) && (f3 == F3_ADD));
        case (f3)
          F3_ADD:  dec.alu_op = (f7 == F7_SUB) ? ALU_SUB : ALU_ADD;
          F3_XOR:  dec.alu_op = ALU_XOR;
          F3_OR:   dec.alu_op = ALU_OR;
          F3_AND:  dec.alu_op = ALU_AND;
          default: dec_legal  = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        dec_legal   = (f3 == F3_LW);
        dec.we      = 1'b1;
        dec.use_imm = 1'b1;
        dec.is_load = 1'b1;
      end
      OPC_STORE: begin
        dec_legal    = (f3 == F3_SW);
        dec.use_imm  = 1'b1;
        dec.is_store = 1'b1;
        dec.rd       = 5'd0;
        dec_imm      = imm_s;
        dec_use_rs2  = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
    dec.valid = if_valid && dec_legal;
  end

  pipe_core_regfile #(.XLEN(XLEN), .NREG(NREG), .AW(RW)) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (mem_wb.valid && mem_wb.we),
    .waddr  (mem_wb.rd[RW-1:0]),
    .wdata  (mem_wb_data),
    .raddr1 (dec.rs1[RW-1:0]),
    .raddr2 (dec.rs2[RW-1:0]),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

  // With bypass only a load in EX blocks ID; without it any producer in EX or MEM does.
  assign use_rs1 = dec.valid;
  assign use_rs2 = dec.valid && dec_use_rs2;
  assign hit_ex  = raw_hit(id_ex.valid, id_ex.we, id_ex.rd, dec.rs1, use_rs1) ||
                   raw_hit(id_ex.valid, id_ex.we, id_ex.rd, dec.rs2, use_rs2);
  assign hit_mem = raw_hit(ex_mem.valid, ex_mem.we, ex_mem.rd, dec.rs1, use_rs1) ||
                   raw_hit(ex_mem.valid, ex_mem.we, ex_mem.rd, dec.rs2, use_rs2);
  assign stall   = FWD_ON ? (hit_ex && id_ex.is_load) : (hit_ex || hit_mem);

  always_comb begin
    sel_a = FWD_RF;
    sel_b = FWD_RF;
    if (FWD_ON) begin
      if (raw_hit(ex_mem.valid && !ex_mem.is_load, ex_mem.we, ex_mem.rd, id_ex.rs1, 1'b1))
        sel_a = FWD_EXMEM;
      else if (raw_hit(mem_wb.valid, mem_wb.we, mem_wb.rd, id_ex.rs1, 1'b1))
        sel_a = FWD_MEMWB;
      if (raw_hit(ex_mem.valid && !ex_mem.is_load, ex_mem.we, ex_mem.rd, id_ex.rs2, 1'b1))
        sel_b = FWD_EXMEM;
      else if (raw_hit(mem_wb.valid, mem_wb.we, mem_wb.rd, id_ex.rs2, 1'b1))
        sel_b = FWD_MEMWB;
    end
  end

  always_comb begin
    case (sel_a)
      FWD_EXMEM: op_a = ex_mem_res;
      FWD_MEMWB: op_a = mem_wb_data;
      default:   op_a = id_ex_a;
    endcase
    case (sel_b)
      FWD_EXMEM: op_b = ex_mem_res;
      FWD_MEMWB: op_b = mem_wb_data;
      default:   op_b = id_ex_b;
    endcase
    alu_b = id_ex.use_imm ? id_ex_imm : op_b;
    case (id_ex.alu_op)
      ALU_SUB: alu_res = op_a - alu_b;
      ALU_AND: alu_res = op_a & alu_b;
      ALU_OR:  alu_res = op_a | alu_b;
      ALU_XOR: alu_res = op_a ^ alu_b;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(alu_b))};
      default: alu_res = op_a + alu_b;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_insn  <= '0;
      if_pc    <= '0;
    end else if (!stall) begin
      pc       <= pc + XLEN'(4);
      if_valid <= 1'b1;
      if_insn  <= imem_insn;
      if_pc    <= pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex        <= '0;
      id_ex_pc     <= '0;
      id_ex_a      <= '0;
      id_ex_b      <= '0;
      id_ex_imm    <= '0;
      ex_mem       <= '0;
      ex_mem_pc    <= '0;
      ex_mem_res   <= '0;
      ex_mem_wdata <= '0;
      mem_wb       <= '0;
      mem_wb_pc    <= '0;
      mem_wb_data  <= '0;
    end else begin
      id_ex           <= stall ? '0 : dec;
      id_ex_pc        <= if_pc;
      id_ex_a         <= rf_rd1;
      id_ex_b         <= rf_rd2;
      id_ex_imm       <= dec_imm;
      ex_mem.valid    <= id_ex.valid;
      ex_mem.is_load  <= id_ex.is_load;
      ex_mem.is_store <= id_ex.is_store;
      ex_mem.we       <= id_ex.we;
      ex_mem.rd       <= id_ex.rd;
      ex_mem_pc       <= id_ex_pc;
      ex_mem_res      <= alu_res;
      ex_mem_wdata    <= op_b;
      mem_wb.valid    <= ex_mem.valid;
      mem_wb.we       <= ex_mem.we;
      mem_wb.rd       <= ex_mem.rd;
      mem_wb_pc       <= ex_mem_pc;
      mem_wb_data     <= ex_mem.is_load  ? dmem_rdata :
                         ex_mem.is_store ? ex_mem_wdata : ex_mem_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      cyc_q     <= '0;
      stall_q   <= '0;
    end else begin
      cyc_q <= cyc_q + 1'b1;
      if (stall) stall_q <= stall_q + 1'b1;
      if (if_valid && !dec_legal) illegal_q <= 1'b1;
    end
  end

  assign imem_addr    = pc;
  assign dmem_addr    = ex_mem_res;
  assign dmem_wdata   = ex_mem_wdata;
  assign dmem_wen     = ex_mem.valid && ex_mem.is_store;
  assign retire_valid = mem_wb.valid;
  assign retire_pc    = mem_wb_pc;
  assign retire_rd    = mem_wb.rd;
  assign retire_data  = mem_wb_data;
  assign illegal_seen = illegal_q;
  assign cycle_cnt    = cyc_q;
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_pipe_core_fwd.sv
// Directed bench for pipe_core_fwd: program vectors with hand-computed retire results plus reset/store sequences.
// Expected stall counts and retire cycles follow the FWD_EN build option.
module tb_pipe_core_fwd;

`ifdef FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst_n;
  logic [31:0] imem_addr, imem_insn, dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_wen, retire_valid, illegal_seen;
  logic [31:0] retire_pc, retire_data;
  logic [4:0]  retire_rd;
  logic [15:0] cycle_cnt, stall_cnt;

  logic [31:0] rom  [64];
  logic [31:0] dmem [64];

  assign imem_insn  = (imem_addr[31:8] == '0 && imem_addr[1:0] == '0) ? rom[imem_addr[7:2]] : NOP;
  assign dmem_rdata = (dmem_addr[31:8] == '0 && dmem_addr[1:0] == '0) ? dmem[dmem_addr[7:2]] : '0;

  pipe_core_fwd dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr    (imem_addr),
    .imem_insn    (imem_insn),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_wen     (dmem_wen),
    .dmem_rdata   (dmem_rdata),
    .retire_valid (retire_valid),
    .retire_pc    (retire_pc),
    .retire_rd    (retire_rd),
    .retire_data  (retire_data),
    .illegal_seen (illegal_seen),
    .cycle_cnt    (cycle_cnt),
    .stall_cnt    (stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] ret_pc[$], ret_data[$];
  logic [4:0]  ret_rd[$];
  int          ret_cyc[$];
  int          wen_cnt, wen_cyc;
  logic [31:0] wen_addr, wen_data;

  typedef struct {
    string       name;
    logic [31:0] i0, i1, i2, i3;
    logic [31:0] rdata;
    logic [31:0] chk_pc;
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
    int          stall;
    logic        ill;
  } vec_t;
  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic [31:0] i0, i1, i2, i3, input logic [31:0] rdata,
                     input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data,
                     input int cyc_f, cyc_n, st_f, st_n, input logic ill);
    vec_t v;
    v.name = n; v.i0 = i0; v.i1 = i1; v.i2 = i2; v.i3 = i3; v.rdata = rdata;
    v.chk_pc = pc; v.rd = rd; v.data = data;
    v.cyc = FWD ? cyc_f : cyc_n;
    v.stall = FWD ? st_f : st_n;
    v.ill = ill;
    vq.push_back(v);
  endtask

  task automatic load_prog(input logic [31:0] i0, i1, i2, i3);
    for (int i = 0; i < 64; i++) rom[i] = NOP;
    rom[0] = i0; rom[1] = i1; rom[2] = i2; rom[3] = i3;
  endtask

  // driver: reset pulse, release on a falling edge, log retires/stores for ncyc cycles
  task automatic run_prog(input int ncyc);
    ret_pc.delete(); ret_data.delete(); ret_rd.delete(); ret_cyc.delete();
    wen_cnt = 0; wen_cyc = -1; wen_addr = '0; wen_data = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      if (retire_valid) begin
        ret_pc.push_back(retire_pc);
        ret_rd.push_back(retire_rd);
        ret_data.push_back(retire_data);
        ret_cyc.push_back(c);
      end
      if (dmem_wen) begin
        wen_cnt++; wen_cyc = c; wen_addr = dmem_addr; wen_data = dmem_wdata;
      end
      @(negedge clk);
    end
  endtask

  function automatic int find_pc(input logic [31:0] pc);
    for (int i = 0; i < ret_pc.size(); i++) if (ret_pc[i] == pc) return i;
    return -1;
  endfunction

  task automatic check_retire(input string name, input logic [31:0] pc, input logic [4:0] rd,
                              input logic [31:0] data, input int cyc);
    int idx;
    idx = find_pc(pc);
    check({name, "/cyc"},  (idx >= 0) ? ret_cyc[idx] : -1, cyc);
    check({name, "/rd"},   (idx >= 0) ? 32'(ret_rd[idx]) : 32'hDEAD_00DD, 32'(rd));
    check({name, "/data"}, (idx >= 0) ? ret_data[idx] : 32'hDEAD_DA7A, data);
  endtask

  initial begin
    int found;
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) begin rom[i] = NOP; dmem[i] = '0; end

    //   name        i0            i1            i2            i3            rdata   pc rd data          cyc f/n st f/n ill
    add("indep",    32'h00500093, 32'h00700113, NOP,          NOP,          0,      4, 2, 32'd7,        5, 5, 0, 0, 0);
    add("raw_alu",  32'h00500093, 32'h00308113, NOP,          NOP,          0,      4, 2, 32'd8,        5, 7, 0, 2, 0);
    add("load_use", 32'h00002183, 32'h00318233, NOP,          NOP,          'h1234, 4, 4, 32'h2468,     6, 7, 1, 2, 0);
    add("store",    32'h00800113, 32'h00212223, NOP,          NOP,          0,      4, 0, 32'd8,        5, 7, 0, 2, 0);
    add("corner",   32'h00900013, 32'hFFF00293, 32'h00128293, 32'h0000007F, 0,      8, 5, 32'd0,        6, 8, 0, 2, 1);
    add("add",      32'h00C00093, 32'h00A00113, 32'h002081B3, NOP,          0,      8, 3, 32'd22,       6, 8, 0, 2, 0);
    add("sub",      32'h00C00093, 32'h00A00113, 32'h402081B3, NOP,          0,      8, 3, 32'd2,        6, 8, 0, 2, 0);
    add("sub_neg",  32'h00C00093, 32'h00A00113, 32'h401101B3, NOP,          0,      8, 3, 32'hFFFFFFFE, 6, 8, 0, 2, 0);
    add("and",      32'h00C00093, 32'h00A00113, 32'h0020F1B3, NOP,          0,      8, 3, 32'd8,        6, 8, 0, 2, 0);
    add("or",       32'h00C00093, 32'h00A00113, 32'h0020E1B3, NOP,          0,      8, 3, 32'd14,       6, 8, 0, 2, 0);
    add("xor",      32'h00C00093, 32'h00A00113, 32'h0020C1B3, NOP,          0,      8, 3, 32'd6,        6, 8, 0, 2, 0);
    add("slti_t",   32'h00C00093, 32'h00A00113, 32'h00D0A193, NOP,          0,      8, 3, 32'd1,        6, 7, 0, 1, 0);
    add("slti_sgn", 32'h00C00093, 32'h00A00113, 32'hFFF0A193, NOP,          0,      8, 3, 32'd0,        6, 7, 0, 1, 0);
    add("xori",     32'h00C00093, 32'h00A00113, 32'hFFF0C193, NOP,          0,      8, 3, 32'hFFFFFFF3, 6, 7, 0, 1, 0);
    add("ori",      32'h00C00093, 32'h00A00113, 32'h0300E193, NOP,          0,      8, 3, 32'h3C,       6, 7, 0, 1, 0);
    add("andi",     32'h00C00093, 32'h00A00113, 32'h0040F193, NOP,          0,      8, 3, 32'd4,        6, 7, 0, 1, 0);

    foreach (vq[i]) begin
      load_prog(vq[i].i0, vq[i].i1, vq[i].i2, vq[i].i3);
      dmem[0] = vq[i].rdata;
      run_prog(16);
      check_retire(vq[i].name, vq[i].chk_pc, vq[i].rd, vq[i].data, vq[i].cyc);
      check({vq[i].name, "/stall_cnt"}, 32'(stall_cnt), 32'(vq[i].stall));
      check({vq[i].name, "/illegal"},   32'(illegal_seen), 32'(vq[i].ill));
      check({vq[i].name, "/cycle_cnt"}, 32'(cycle_cnt), 32'd16);
    end

    // reset mid-cycle after 10 running cycles
    load_prog(32'h00500093, 32'h00700113, NOP, NOP);
    run_prog(10);
    check("pre_reset/cycle_cnt", 32'(cycle_cnt), 32'd10);
    check("pre_reset/imem_addr", imem_addr, 32'd40);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("reset/imem_addr", imem_addr, 32'd0);
    check("reset/retire_valid", 32'(retire_valid), 32'd0);
    check("reset/dmem_wen", 32'(dmem_wen), 32'd0);
    check("reset/cycle_cnt", 32'(cycle_cnt), 32'd0);
    check("reset/stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset/illegal", 32'(illegal_seen), 32'd0);

    // retire order and first-instruction latency
    load_prog(32'h00500093, 32'h00308113, NOP, NOP);
    run_prog(16);
    check("order/pc0",   ret_pc.size() > 1 ? ret_pc[0] : 32'hDEAD_0000, 32'd0);
    check("order/cyc0",  ret_cyc.size() > 1 ? ret_cyc[0] : -1, 32'd4);
    check("order/data0", ret_data.size() > 1 ? ret_data[0] : 32'hDEAD_0000, 32'd5);
    check("order/pc1",   ret_pc.size() > 1 ? ret_pc[1] : 32'hDEAD_0000, 32'd4);

    // load retire and x0 handling
    load_prog(32'h00002183, 32'h00318233, NOP, NOP);
    dmem[0] = 32'h1234;
    run_prog(16);
    check_retire("lw", 0, 3, 32'h1234, 4);
    load_prog(32'h00900013, 32'hFFF00293, 32'h00128293, 32'h0000007F);
    run_prog(16);
    check_retire("x0_write", 0, 0, 32'd9, 4);
    check_retire("x0_read", 4, 5, 32'hFFFFFFFF, 5);
    check("illegal/no_retire", find_pc(12), -1);

    // store strobe: exactly one cycle, address and data
    load_prog(32'h00800113, 32'h00212223, NOP, NOP);
    run_prog(16);
    check("store/wen_cnt", wen_cnt, 1);
    check("store/addr", wen_addr, 32'd12);
    check("store/wdata", wen_data, 32'd8);
    check("store/wen_cyc", wen_cyc, FWD ? 4 : 6);

    // reset while the store strobe is high drops it at once
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      if (dmem_wen) found = 1;
      else @(negedge clk);
    end
    check("drop/wen_seen", found, 1);
    rst_n = 1'b0;
    #1;
    check("drop/dmem_wen", 32'(dmem_wen), 32'd0);
    check("drop/dmem_addr", dmem_addr, 32'd0);
    check("drop/dmem_wdata", dmem_wdata, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
